// File: rtl/mem_port_arbiter_pkg.sv
// Shared requester ids, FSM encoding and helpers for mem_port_arbiter.
// Build option: MEM_PORT_ARB_RR_EN selects round-robin instead of fixed priority.
package mem_arb_pkg;

    localparam int N_REQ = 3;

    localparam logic [1:0] REQ_FETCH = 2'd0;
    localparam logic [1:0] REQ_DATA  = 2'd1;
    localparam logic [1:0] REQ_DBG   = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    function automatic logic [1:0] nextId(input logic [1:0] id);
        return (id == REQ_DBG) ? REQ_FETCH : id + 2'd1;
    endfunction

    function automatic logic [N_REQ-1:0] idToOneHot(input logic [1:0] id);
        return N_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshake and memory-side bus of the arbiter; slave = arbiter side, master = requesters/memory.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    busy;
    logic [1:0]              owner;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection for mem_port_arbiter.
// MEM_PORT_ARB_RR_EN: round-robin from i_ptr; otherwise fixed priority 1 > 0 > 2.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
`ifdef MEM_PORT_ARB_RR_EN
    input  logic [1:0]       i_ptr,
`endif
    output logic [1:0]       o_winner,
    output logic             o_valid
);

`ifdef MEM_PORT_ARB_RR_EN
    logic [1:0] w_cand0;
    logic [1:0] w_cand1;
    logic [1:0] w_cand2;

    assign w_cand0 = i_ptr;
    assign w_cand1 = nextId(w_cand0);
    assign w_cand2 = nextId(w_cand1);

    // Candidates are tested farthest-first so the one nearest the pointer overrides.
    always_comb begin
        o_winner = REQ_FETCH;
        o_valid  = |i_req;
        if (i_req[w_cand2]) o_winner = w_cand2;
        if (i_req[w_cand1]) o_winner = w_cand1;
        if (i_req[w_cand0]) o_winner = w_cand0;
    end
`else
    always_comb begin
        o_winner = REQ_FETCH;
        o_valid  = |i_req;
        if (i_req[REQ_DBG])   o_winner = REQ_DBG;
        if (i_req[REQ_FETCH]) o_winner = REQ_FETCH;
        if (i_req[REQ_DATA])  o_winner = REQ_DATA;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch, load/store and debug with one access in flight.
// Build option: MEM_PORT_ARB_RR_EN enables round-robin arbitration (default fixed priority).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] WAIT_LAST = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_owner;
    logic [1:0]         r_cnt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic [N_REQ-1:0]   r_done;
    logic [1:0]         w_winner;
    logic               w_valid;
    logic               w_launch;
    logic               w_access;
    logic               w_readDone;

`ifdef MEM_PORT_ARB_RR_EN
    logic [1:0] r_ptr;
`endif

    mem_arb_pick u_pick (
        .i_req    (bus.req),
`ifdef MEM_PORT_ARB_RR_EN
        .i_ptr    (r_ptr),
`endif
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_valid) begin
                    w_launch = 1'b1;
                    w_next   = ACCESS;
                end else begin
                    w_next = IDLE;
                end
            end
            ACCESS:  w_next = (MEM_LAT == 1) ? DONE : WAIT;
            WAIT:    if (r_cnt == WAIT_LAST) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_owner <= REQ_FETCH;
            r_cnt   <= 2'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == DONE) ? idToOneHot(r_owner) : '0;
            r_cnt   <= (r_state == WAIT && r_cnt != WAIT_LAST) ? r_cnt + 2'd1 : 2'd0;
            if (w_launch) begin
                r_owner <= w_winner;
                r_we    <= bus.we[w_winner];
                r_addr  <= bus.addr[w_winner*ADDR_W +: ADDR_W];
                r_wdata <= bus.wdata[w_winner*DATA_W +: DATA_W];
            end
            if (w_readDone) r_rdata <= bus.mem_rdata;
        end
    end

`ifdef MEM_PORT_ARB_RR_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= REQ_FETCH;
        end else if (r_state == ACCESS) begin
            r_ptr <= nextId(r_owner);
        end
    end
`endif

    assign w_access   = (r_state == ACCESS);
    assign w_readDone = (r_state == DONE) && !r_we;

    assign bus.gnt       = w_access ? idToOneHot(r_owner) : '0;
    assign bus.mem_en    = w_access;
    assign bus.mem_we    = w_access & r_we;
    assign bus.mem_addr  = w_access ? r_addr : '0;
    assign bus.mem_wdata = w_access ? r_wdata : '0;
    assign bus.done      = r_done;
    assign bus.busy      = (r_state != IDLE);
    assign bus.owner     = r_owner;
    // Memory data arrives in the done cycle itself, so it bypasses the hold register then.
    assign bus.rdata     = w_readDone ? bus.mem_rdata : r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with MEM_LAT 1, 2, 3 each backed by a small memory model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        pokeEn = 1'b0;
    logic [7:0]  pokeAddr = 8'h00;
    logic [15:0] pokeData = 16'h0000;

    logic [2:0]  req[3];
    logic [2:0]  we[3];
    logic [47:0] addr[3];
    logic [47:0] wdata[3];
    logic [2:0]  gnt[3];
    logic [2:0]  done[3];
    logic [15:0] rdata[3];
    logic [15:0] memAddr[3];
    logic [15:0] memWdata[3];
    logic        memEn[3];
    logic        memWe[3];
    logic        busy[3];
    logic [1:0]  owner[3];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : gInst
        localparam int LAT = g + 1;

        mem_port_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

        logic [15:0] mem [256];
        logic [15:0] pipe [LAT];

        assign bus.req   = req[g];
        assign bus.we    = we[g];
        assign bus.addr  = addr[g];
        assign bus.wdata = wdata[g];
        assign gnt[g]      = bus.gnt;
        assign done[g]     = bus.done;
        assign rdata[g]    = bus.rdata;
        assign memEn[g]    = bus.mem_en;
        assign memWe[g]    = bus.mem_we;
        assign memAddr[g]  = bus.mem_addr;
        assign memWdata[g] = bus.mem_wdata;
        assign busy[g]     = bus.busy;
        assign owner[g]    = bus.owner;
        assign bus.mem_rdata = pipe[LAT-1];

        always @(posedge clock) begin
            if (pokeEn) mem[pokeAddr] <= pokeData;
            else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:0]] : 16'h0000;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(LAT)) dut (
            .clock   (clock),
            .reset_n (reset_n),
            .bus     (bus)
        );
    end

    function automatic logic [31:0] bitOf(input int id);
        return 32'd1 << id;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int i, input int id, input logic w, input logic [15:0] a, input logic [15:0] d);
        req[i][id]           = 1'b1;
        we[i][id]            = w;
        addr[i][id*16 +: 16]  = a;
        wdata[i][id*16 +: 16] = d;
    endtask

    task automatic dropReq(input int i, input int id);
        req[i][id] = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        @(negedge clock);
        pokeEn   = 1'b1;
        pokeAddr = a;
        pokeData = d;
        @(negedge clock);
        pokeEn = 1'b0;
    endtask

    task automatic runAccess(input string tag, input int i, input int id, input logic w,
                             input logic [15:0] a, input logic [15:0] d, input int lat,
                             input logic [15:0] expRdata);
        @(negedge clock);
        applyStimulus(i, id, w, a, d);
        @(negedge clock);
        checkOutput({tag, ".gnt"}, 32'(gnt[i]), bitOf(id));
        checkOutput({tag, ".memEn"}, 32'(memEn[i]), 32'd1);
        checkOutput({tag, ".memWe"}, 32'(memWe[i]), 32'(w));
        checkOutput({tag, ".memAddr"}, 32'(memAddr[i]), 32'(a));
        if (w) checkOutput({tag, ".memWdata"}, 32'(memWdata[i]), 32'(d));
        checkOutput({tag, ".owner"}, 32'(owner[i]), 32'(id));
        dropReq(i, id);
        for (int c = 1; c < lat; c++) begin
            @(negedge clock);
            checkOutput({tag, ".waitDone"}, 32'(done[i]), 32'd0);
            checkOutput({tag, ".waitBusy"}, 32'(busy[i]), 32'd1);
        end
        @(negedge clock);
        checkOutput({tag, ".done"}, 32'(done[i]), bitOf(id));
        checkOutput({tag, ".rdata"}, 32'(rdata[i]), 32'(expRdata));
        @(negedge clock);
        checkOutput({tag, ".idle"}, 32'(busy[i]), 32'd0);
        checkOutput({tag, ".rdataHeld"}, 32'(rdata[i]), 32'(expRdata));
    endtask

    initial begin
        int order[3];
        int grantCnt[3];
        int total;
        int run;
        int maxRun;

`ifdef MEM_PORT_ARB_RR_EN
        order = '{0, 1, 2};
`else
        order = '{1, 0, 2};
`endif
        for (int i = 0; i < 3; i++) begin
            req[i]   = 3'b000;
            we[i]    = 3'b000;
            addr[i]  = 48'h0;
            wdata[i] = 48'h0;
        end

        reset_n = 1'b0;
        poke(8'h10, 16'hBEEF);
        poke(8'h50, 16'hA5A5);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset%0d.gnt", i), 32'(gnt[i]), 32'd0);
            checkOutput($sformatf("reset%0d.done", i), 32'(done[i]), 32'd0);
            checkOutput($sformatf("reset%0d.memEn", i), 32'(memEn[i]), 32'd0);
            checkOutput($sformatf("reset%0d.busy", i), 32'(busy[i]), 32'd0);
            checkOutput($sformatf("reset%0d.owner", i), 32'(owner[i]), 32'd0);
            checkOutput($sformatf("reset%0d.rdata", i), 32'(rdata[i]), 32'd0);
        end
        reset_n = 1'b1;

        // Simultaneous requests on the MEM_LAT=1 instance: one grant every 2 cycles.
        @(negedge clock);
        for (int id = 0; id < 3; id++) applyStimulus(0, id, 1'b0, 16'h0050, 16'h0000);
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            checkOutput($sformatf("prio.gnt%0d", n), 32'(gnt[0]), bitOf(order[n]));
            checkOutput($sformatf("prio.memEn%0d", n), 32'(memEn[0]), 32'd1);
            dropReq(0, order[n]);
            @(negedge clock);
            checkOutput($sformatf("prio.done%0d", n), 32'(done[0]), bitOf(order[n]));
            checkOutput($sformatf("prio.gap%0d", n), 32'(memEn[0]), 32'd0);
        end
        @(negedge clock);
        checkOutput("prio.idle", 32'(busy[0]), 32'd0);

        runAccess("read1", 0, 0, 1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF);

        runAccess("preRead", 1, 1, 1'b0, 16'h0050, 16'h0000, 2, 16'hA5A5);
        runAccess("write", 1, 1, 1'b1, 16'h0040, 16'h1234, 2, 16'hA5A5);
        runAccess("readBack", 1, 1, 1'b0, 16'h0040, 16'h0000, 2, 16'h1234);

        // All three requesters held high for 20 accesses.
        grantCnt = '{0, 0, 0};
        total = 0;
        run = 0;
        maxRun = 0;
        @(negedge clock);
        for (int id = 0; id < 3; id++) applyStimulus(0, id, 1'b0, 16'h0050, 16'h0000);
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (gnt[0] != 3'b000) begin
                total++;
                for (int id = 0; id < 3; id++) if (gnt[0][id]) grantCnt[id]++;
                if (gnt[0][2]) run = 0;
                else begin
                    run++;
                    if (run > maxRun) maxRun = run;
                end
            end
        end
        req[0] = 3'b000;
        checkOutput("starve.total", 32'(total), 32'd20);
`ifdef MEM_PORT_ARB_RR_EN
        checkOutput("starve.maxGap", 32'(maxRun <= 2), 32'd1);
        checkOutput("starve.dbgMin", 32'(grantCnt[2] >= 6), 32'd1);
`else
        checkOutput("starve.dbgGrants", 32'(grantCnt[2]), 32'd0);
        checkOutput("starve.dataGrants", 32'(grantCnt[1]), 32'd20);
`endif
        @(negedge clock);
        checkOutput("starve.idle", 32'(busy[0]), 32'd0);

        // Reset during WAIT on the MEM_LAT=3 instance.
        @(negedge clock);
        applyStimulus(2, 2, 1'b0, 16'h0010, 16'h0000);
        @(negedge clock);
        checkOutput("rstWait.gnt", 32'(gnt[2]), bitOf(2));
        dropReq(2, 2);
        @(negedge clock);
        checkOutput("rstWait.busy", 32'(busy[2]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rstWait.gnt0", 32'(gnt[2]), 32'd0);
        checkOutput("rstWait.done0", 32'(done[2]), 32'd0);
        checkOutput("rstWait.memEn0", 32'(memEn[2]), 32'd0);
        checkOutput("rstWait.busy0", 32'(busy[2]), 32'd0);
        checkOutput("rstWait.owner0", 32'(owner[2]), 32'd0);
        checkOutput("rstWait.rdata0", 32'(rdata[2]), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checkOutput($sformatf("rstWait.noDone%0d", c), 32'(done[2]), 32'd0);
        end
        reset_n = 1'b1;
        runAccess("postRst", 2, 2, 1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
